jesd204_rx_ilas_monitor: RTL

Per-lane receive-side monitor for the JESD204B link layer, sitting after the 8b/10b decoder and alignment stage of one lane. It tracks code group synchronization (/K28.5/), then walks the initial lane alignment sequence (ILAS) multiframe by multiframe, checking /R/, /Q/ and /A/ markers. It extracts the 14 link-configuration octets from ILAS multiframe 1 as four 32-bit words, then reports data phase. It is the receive counterpart of the transmit-side CGS/ILAS generator for a 4-octet data path.

---
 rtl/jesd204_rx_ilas_monitor.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/jesd204_rx_ilas_monitor.sv
// Per-lane JESD204B receive monitor: CGS lock, ILAS multiframe checking, config capture, data phase.
// Optional macro JESD204_RX_ILAS_STRICT_A_EN checks /A/ at the end of every ILAS multiframe.
module jesd204_rx_ilas_monitor #(
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [8*DATA_PATH_WIDTH-1:0]   rx_data,
    input  logic [DATA_PATH_WIDTH-1:0]     rx_charisk,
    input  logic [9:0]                     cfg_octets_per_multiframe,
    input  logic [7:0]                     cfg_mframes_per_ilas,
    output logic [1:0]                     status_state,
    output logic                           rx_ready,
    output logic                           ilas_done,
    output logic                           err_ilas,
    output logic                           ilas_config_wr,
    output logic [1:0]                     ilas_config_addr,
    output logic [31:0]                    ilas_config_data
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'b00,
        ST_CGS  = 2'b01,
        ST_ILAS = 2'b10,
        ST_DATA = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic [7:0]  mframe_cnt_q, mframe_cnt_d;
    logic [1:0]  kcnt_q, kcnt_d;
    logic        rx_ready_q, rx_ready_d;
    logic        ilas_done_q, ilas_done_d;
    logic        err_ilas_q, err_ilas_d;
    logic        cfg_wr_q, cfg_wr_d;
    logic [1:0]  cfg_addr_q, cfg_addr_d;
    logic [31:0] cfg_data_q, cfg_data_d;

    logic all_k, is_r, is_q, is_a;
    logic beat_first, beat_last, mf_final, a_check, ilas_viol;
    logic unused_cfg_lsbs;

    // Multiframe length is a multiple of 4 octets, so the two LSBs carry no information.
    assign unused_cfg_lsbs = ^cfg_octets_per_multiframe[1:0];

    assign all_k = (rx_charisk == 4'hF) && (rx_data == 32'hBCBC_BCBC);
    assign is_r  = (rx_data[7:0]   == 8'h1C) && rx_charisk[0];
    assign is_q  = (rx_data[15:8]  == 8'h9C) && rx_charisk[1];
    assign is_a  = (rx_data[31:24] == 8'h7C) && rx_charisk[3];

    // beats_per_mf - 1 equals cfg[9:2], so compare directly and avoid a 9-bit sum.
    assign beat_first = (beat_cnt_q == 8'd0);
    assign beat_last  = (beat_cnt_q == cfg_octets_per_multiframe[9:2]);
    assign mf_final   = (mframe_cnt_q == cfg_mframes_per_ilas);

`ifdef JESD204_RX_ILAS_STRICT_A_EN
    assign a_check = 1'b1;
`else
    assign a_check = mf_final;
`endif

    assign ilas_viol = (beat_first && !is_r)
                    || (beat_first && (mframe_cnt_q == 8'd1) && !is_q)
                    || (beat_last && a_check && !is_a);

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        mframe_cnt_d = mframe_cnt_q;
        kcnt_d       = kcnt_q;
        ilas_done_d  = 1'b0;
        err_ilas_d   = 1'b0;
        cfg_wr_d     = 1'b0;
        cfg_addr_d   = 2'd0;
        cfg_data_d   = 32'd0;

        case (state_q)
            ST_WAIT: begin
                if (all_k) begin
                    if (kcnt_q == 2'd3) begin
                        state_d = ST_CGS;
                        kcnt_d  = 2'd0;
                    end else begin
                        kcnt_d = kcnt_q + 2'd1;
                    end
                end else begin
                    kcnt_d = 2'd0;
                end
            end
            ST_CGS: begin
                if (all_k) begin
                    state_d = ST_CGS;
                end else if (is_r) begin
                    // The /R/ beat itself is beat 0 of multiframe 0.
                    state_d      = ST_ILAS;
                    beat_cnt_d   = 8'd1;
                    mframe_cnt_d = 8'd0;
                end else begin
                    state_d    = ST_WAIT;
                    err_ilas_d = 1'b1;
                    kcnt_d     = 2'd0;
                end
            end
            ST_ILAS: begin
                if (ilas_viol) begin
                    state_d      = ST_WAIT;
                    err_ilas_d   = 1'b1;
                    beat_cnt_d   = 8'd0;
                    mframe_cnt_d = 8'd0;
                    kcnt_d       = 2'd0;
                end else begin
                    // ilas_config_wr is a one-cycle strobe with no backpressure; addr/data valid only with it.
                    if ((mframe_cnt_q == 8'd1) && (beat_cnt_q[7:2] == 6'd0)) begin
                        cfg_wr_d   = 1'b1;
                        cfg_addr_d = beat_cnt_q[1:0];
                        cfg_data_d = beat_first ? {rx_data[31:16], 16'h0000} : rx_data;
                    end
                    if (beat_last) begin
                        beat_cnt_d = 8'd0;
                        if (mf_final) begin
                            state_d     = ST_DATA;
                            ilas_done_d = 1'b1;
                        end else begin
                            mframe_cnt_d = mframe_cnt_q + 8'd1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            ST_DATA: begin
                if (all_k) begin
                    state_d = ST_CGS;
                    kcnt_d  = 2'd0;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        rx_ready_d = (state_d == ST_DATA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_WAIT;
            beat_cnt_q   <= 8'd0;
            mframe_cnt_q <= 8'd0;
            kcnt_q       <= 2'd0;
            rx_ready_q   <= 1'b0;
            ilas_done_q  <= 1'b0;
            err_ilas_q   <= 1'b0;
            cfg_wr_q     <= 1'b0;
            cfg_addr_q   <= 2'd0;
            cfg_data_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            mframe_cnt_q <= mframe_cnt_d;
            kcnt_q       <= kcnt_d;
            rx_ready_q   <= rx_ready_d;
            ilas_done_q  <= ilas_done_d;
            err_ilas_q   <= err_ilas_d;
            cfg_wr_q     <= cfg_wr_d;
            cfg_addr_q   <= cfg_addr_d;
            cfg_data_q   <= cfg_data_d;
        end
    end

    assign status_state     = state_q;
    assign rx_ready         = rx_ready_q;
    assign ilas_done        = ilas_done_q;
    assign err_ilas         = err_ilas_q;
    assign ilas_config_wr   = cfg_wr_q;
    assign ilas_config_addr = cfg_addr_q;
    assign ilas_config_data = cfg_data_q;

endmodule
